mul_div_unit: RTL and testbench

Multi-cycle signed 32×32 multiply and 32/32 divide unit on the CPU datapath. It sits directly upstream of the 64-bit Z result register pair (ZHI/ZLO). It takes operands sampled from the bus-side A/Y operand registers and produces a 64-bit result that the control unit latches into ZHI/ZLO when `done` pulses. The single-cycle ALU handles all other operations; this block handles only MUL and DIV.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/mul_div_unit.sv | 145 ++++++++++++++
 tb/tb_mul_div_unit.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions used by the multiply/divide unit.
package cpu_pkg;

    // Operation select for the multi-cycle unit
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Number of shift/add iterations for a 32-bit operation
    localparam int MD_ITER = 32;

    // Sequencer states of the multiply/divide unit
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring) unit
// feeding the ZHI/ZLO result pair. Both operations share one 2W+1 bit
// shift register and one W+1 bit adder/subtractor.
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] z_hi,
    output logic [DATA_WIDTH-1:0] z_lo,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);
    import cpu_pkg::*;

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH - 1);

    // Two's complement negate when requested
    function automatic logic [W-1:0] cond_negate(input logic [W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Unsigned magnitude of a signed operand; the most negative value maps to 2^(W-1)
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
        return cond_negate(v, v[W-1]);
    endfunction

    md_state_t        state;
    logic [CNT_W-1:0] count;
    logic             op_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;

    // MUL layout: {P_hi, P_lo, q_-1}; DIV layout: {R (W+1 bits), Q (W bits)}
    logic [2*W:0]     acc;
    logic [2*W:0]     acc_next;

    logic [W:0]       add_x;
    logic [W:0]       add_y;
    logic [W:0]       add_sum;
    logic             add_sub;
    logic [W-1:0]     mag_b;

    assign mag_b = magnitude(b_r);

    // One iteration of Booth recoding or restoring division through the shared adder
    always_comb begin
        add_x    = '0;
        add_y    = '0;
        add_sub  = 1'b0;
        acc_next = acc;
        if (op_r == OP_MUL) begin
            add_x = {acc[2*W], acc[2*W:W+1]};
            case (acc[1:0])
                2'b01:   add_y = {a_r[W-1], a_r};
                2'b10: begin
                    add_y   = {a_r[W-1], a_r};
                    add_sub = 1'b1;
                end
                default: add_y = '0;
            endcase
        end else begin
            add_x   = {acc[2*W-1:W], acc[W-1]};
            add_y   = {1'b0, mag_b};
            add_sub = 1'b1;
        end
        add_sum = add_x + (add_y ^ {(W+1){add_sub}}) + {{W{1'b0}}, add_sub};
        if (op_r == OP_MUL) begin
            acc_next = {add_sum, acc[W:1]};
        end else if (!add_sum[W]) begin
            acc_next = {add_sum, acc[W-2:0], 1'b1};
        end else begin
            acc_next = {add_x, acc[W-2:0], 1'b0};
        end
    end

    // Sequencer with registered status and result outputs
    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            count       <= '0;
            op_r        <= OP_MUL;
            a_r         <= '0;
            b_r         <= '0;
            acc         <= '0;
            z_hi        <= '0;
            z_lo        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        count       <= CNT_INIT;
                        op_r        <= op;
                        a_r         <= a;
                        b_r         <= b;
                        acc         <= (op == OP_MUL) ? {{W{1'b0}}, b, 1'b0}
                                                      : {{(W+1){1'b0}}, magnitude(a)};
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (op_r == OP_MUL) begin
                        z_hi <= acc[2*W:W+1];
                        z_lo <= acc[W:1];
                    end else if (b_r == '0) begin
                        z_hi        <= a_r;
                        z_lo        <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        z_hi <= cond_negate(acc[2*W-1:W], a_r[W-1]);
                        z_lo <= cond_negate(acc[W-1:0], a_r[W-1] ^ b_r[W-1]);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a transaction-level model predicts
// every output each cycle, plus directed cases with literal expectations.
module tb_mul_div_unit;

    localparam int DONE_EDGE = 33;
    localparam int PERIOD    = 10;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        op    = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Model state: edges elapsed since the accepting edge, -1 when idle
    int          phase   = -1;
    logic [31:0] pend_hi = '0;
    logic [31:0] pend_lo = '0;
    logic        pend_dz = 1'b0;
    logic [31:0] exp_zhi = '0;
    logic [31:0] exp_zlo = '0;
    logic        exp_dbz = 1'b0;

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .z_hi        (z_hi),
        .z_lo        (z_lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #(PERIOD/2) clock = ~clock;

    // Reference arithmetic using plain 64-bit signed math
    function automatic void model_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sx;
        longint sy;
        longint p;
        longint q;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = 1'b0;
        if (o == 1'b0) begin
            p  = sx * sy;
            hi = p[63:32];
            lo = p[31:0];
        end else if (y == 32'd0) begin
            hi = x;
            lo = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Transaction-level model advanced on every rising edge
    always @(posedge clock) begin : model
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        model_op(op, a, b, hi, lo, dz);
        if (clear) begin
            phase   <= -1;
            exp_zhi <= '0;
            exp_zlo <= '0;
            exp_dbz <= 1'b0;
        end else if (start && (phase < 0 || phase == DONE_EDGE)) begin
            phase   <= 0;
            pend_hi <= hi;
            pend_lo <= lo;
            pend_dz <= dz;
            exp_dbz <= 1'b0;
        end else if (phase >= 0 && phase < DONE_EDGE) begin
            phase <= phase + 1;
            if (phase == DONE_EDGE - 1) begin
                exp_zhi <= pend_hi;
                exp_zlo <= pend_lo;
                exp_dbz <= pend_dz;
            end
        end else begin
            phase <= -1;
        end
    end

    // Compare every output against the model on the falling edge
    always @(negedge clock) begin
        if (check_en) begin
            checkOutput("busy", 64'(busy), 64'(phase >= 0 && phase < DONE_EDGE));
            checkOutput("done", 64'(done), 64'(phase == DONE_EDGE));
            checkOutput("z_hi", 64'(z_hi), 64'(exp_zhi));
            checkOutput("z_lo", 64'(z_lo), 64'(exp_zlo));
            checkOutput("div_by_zero", 64'(div_by_zero), 64'(exp_dbz));
        end
    end

    // Pulse start for one edge; called #1 after a rising edge
    task automatic applyStimulus(input logic o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done, optionally wiggling inputs that must be ignored
    task automatic waitDone(input bit noise, output int edges);
        edges = 0;
        while (edges < 60) begin
            @(posedge clock);
            #1;
            edges++;
            if (done) break;
            if (noise) begin
                op    = 1'($urandom_range(0, 1));
                a     = $urandom;
                b     = $urandom;
                start = (edges < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("done seen", 64'(done), 64'd1);
    endtask

    task automatic runDirected(input string name, input logic o, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        int edges;
        applyStimulus(o, x, y);
        waitDone(1'b0, edges);
        checkOutput({name, " latency"}, 64'(edges), 64'(DONE_EDGE));
        checkOutput({name, " z_hi"}, 64'(z_hi), 64'(ehi));
        checkOutput({name, " z_lo"}, 64'(z_lo), 64'(elo));
        checkOutput({name, " dbz"}, 64'(div_by_zero), 64'(edz));
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          edges;
        time         t_first;
        time         t_second;

        // Pin the reference model with hand-computed values
        model_op(1'b0, 32'hFFFF_FFF9, 32'd6, hi, lo, dz);
        checkOutput("model mul -7*6", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
        model_op(1'b1, 32'hFFFF_FF9C, 32'd7, hi, lo, dz);
        checkOutput("model div -100/7", {hi, lo}, 64'hFFFF_FFFE_FFFF_FFF2);
        model_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, hi, lo, dz);
        checkOutput("model div min/-1", {hi, lo}, 64'h0000_0000_8000_0000);

        // Reset state
        clear = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset z", {z_hi, z_lo}, 64'd0);
        checkOutput("reset dbz", 64'(div_by_zero), 64'd0);
        clear    = 1'b0;
        check_en = 1'b1;
        @(posedge clock);
        #1;

        // Directed arithmetic cases
        runDirected("mul -7*6", 1'b0, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
        @(posedge clock); #1;
        runDirected("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        @(posedge clock); #1;
        runDirected("div 100/7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        @(posedge clock); #1;
        runDirected("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
        @(posedge clock); #1;
        runDirected("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        @(posedge clock); #1;
        runDirected("div 55/0", 1'b1, 32'd55, 32'd0, 32'd55, 32'hFFFF_FFFF, 1'b1);
        @(posedge clock); #1;

        // Next accepted start clears div_by_zero; then back-to-back with an ignored mid-run start
        applyStimulus(1'b0, 32'd3, 32'd4);
        checkOutput("dbz cleared at start", 64'(div_by_zero), 64'd0);
        checkOutput("busy after start", 64'(busy), 64'd1);
        waitDone(1'b0, edges);
        t_first = $time;
        checkOutput("b2b mul z", {z_hi, z_lo}, 64'd12);
        applyStimulus(1'b1, 32'd9, 32'd2);
        repeat (5) @(posedge clock);
        #1;
        applyStimulus(1'b0, 32'd1, 32'd1);
        waitDone(1'b0, edges);
        t_second = $time;
        checkOutput("b2b done spacing", 64'(t_second - t_first), 64'(34 * PERIOD));
        checkOutput("b2b div z", {z_hi, z_lo}, {32'd1, 32'd4});
        @(posedge clock); #1;

        // Clear in the middle of a divide
        applyStimulus(1'b1, 32'd1000, 32'd3);
        repeat (10) @(posedge clock);
        #1;
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        checkOutput("clear busy", 64'(busy), 64'd0);
        checkOutput("clear done", 64'(done), 64'd0);
        checkOutput("clear z", {z_hi, z_lo}, 64'd0);
        runDirected("mul 5*5", 1'b0, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
            applyStimulus(1'($urandom_range(0, 1)), randOperand(), randOperand());
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 30)) @(posedge clock);
                #1;
                clear = 1'b1;
                @(posedge clock);
                #1;
                clear = 1'b0;
            end else begin
                waitDone(1'b1, edges);
            end
        end

        @(posedge clock);
        @(negedge clock);
        #1;
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
